primogen_seq: RTL and testbench



---
 rtl/primogen_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_primogen_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/primogen_seq.sv
// Random-access front end for one primogen: steps or restarts the generator
// until it sits on the requested prime index, then returns that prime.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_INIT    | gen_rst pulse after reset
// S_SYNC    | wait for generator ready after INIT
// S_IDLE    | accept a request, decide between hit, step and restart
// S_RESTART | gen_rst pulse because the target is behind or position unknown
// S_RSYNC   | wait for generator ready after RESTART
// S_CHECK   | compare current index against target
// S_STEP    | one-cycle gen_go pulse
// S_WAIT_LO | wait for generator to go busy
// S_WAIT_HI | wait for generator to finish the step
// S_RESP    | hold response until the client takes it
module primogen_seq #(
    parameter int WIDTH   = 16,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    input  logic [IDX_W-1:0] req_idx_i,
    output logic             req_ready_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_prime_o,
    output logic             resp_err_o,
    output logic             gen_rst_o,
    output logic             gen_go_o,
    input  logic             gen_ready_i,
    input  logic             gen_error_i,
    input  logic [WIDTH-1:0] gen_res_i
);

    localparam int               TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMAX    = TW'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    typedef enum logic [3:0] {
        S_INIT,
        S_SYNC,
        S_IDLE,
        S_RESTART,
        S_RSYNC,
        S_CHECK,
        S_STEP,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RESP
    } state_e;

    state_e           state_q,      state_d;
    logic [IDX_W-1:0] cur_idx_q,    cur_idx_d;
    logic [IDX_W-1:0] tgt_q,        tgt_d;
    logic             pos_valid_q,  pos_valid_d;
    logic [TW-1:0]    timer_q,      timer_d;
    logic             req_ready_q,  req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_prime_q, resp_prime_d;
    logic             resp_err_q,   resp_err_d;
    logic             gen_go_q,     gen_go_d;
    logic             gen_rst_q,    gen_rst_d;

    logic timeout;
    logic counting;

    assign timeout  = (timer_q == TMAX);
    assign counting = (state_q == S_SYNC) || (state_q == S_RSYNC) ||
                      (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        tgt_d        = tgt_q;
        pos_valid_d  = pos_valid_q;
        timer_d      = timer_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_prime_d = resp_prime_q;
        resp_err_d   = resp_err_q;
        gen_go_d     = 1'b0;
        gen_rst_d    = 1'b0;

        case (state_q)
            S_INIT: begin
                state_d = S_SYNC;
            end
            S_SYNC: begin
                if (gen_ready_i && !gen_error_i) begin
                    cur_idx_d   = '0;
                    pos_valid_d = 1'b1;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (gen_error_i || timeout) begin
                    pos_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    tgt_d       = req_idx_i;
                    req_ready_d = 1'b0;
                    if (pos_valid_q && req_idx_i == cur_idx_q) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_prime_d = gen_res_i;
                        state_d      = S_RESP;
                    end else if (pos_valid_q && req_idx_i > cur_idx_q) begin
                        gen_go_d = 1'b1;
                        state_d  = S_STEP;
                    end else begin
                        gen_rst_d = 1'b1;
                        state_d   = S_RESTART;
                    end
                end
            end
            S_RESTART: begin
                state_d = S_RSYNC;
            end
            S_RSYNC: begin
                if (gen_ready_i && !gen_error_i) begin
                    cur_idx_d   = '0;
                    pos_valid_d = 1'b1;
                    state_d     = S_CHECK;
                end else if (gen_error_i || timeout) begin
                    pos_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_prime_d = '0;
                    state_d      = S_RESP;
                end
            end
            S_CHECK: begin
                // The saturation guard keeps cur_idx from ever wrapping.
                if (cur_idx_q == tgt_q || cur_idx_q == IDX_MAX) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_prime_d = gen_res_i;
                    state_d      = S_RESP;
                end else begin
                    gen_go_d = 1'b1;
                    state_d  = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if ((gen_ready_i && gen_error_i) || timeout) begin
                    pos_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_prime_d = '0;
                    state_d      = S_RESP;
                end else if (!gen_ready_i) begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if ((gen_ready_i && gen_error_i) || (!gen_ready_i && timeout)) begin
                    pos_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_prime_d = '0;
                    state_d      = S_RESP;
                end else if (gen_ready_i) begin
                    cur_idx_d = cur_idx_q + 1'b1;
                    state_d   = S_CHECK;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Timer restarts on every state change and saturates at TIMEOUT.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (counting && !timeout) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_INIT;
            cur_idx_q    <= '0;
            tgt_q        <= '0;
            pos_valid_q  <= 1'b0;
            timer_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_prime_q <= '0;
            resp_err_q   <= 1'b0;
            gen_go_q     <= 1'b0;
            gen_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            tgt_q        <= tgt_d;
            pos_valid_q  <= pos_valid_d;
            timer_q      <= timer_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_prime_q <= resp_prime_d;
            resp_err_q   <= resp_err_d;
            gen_go_q     <= gen_go_d;
            gen_rst_q    <= gen_rst_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_prime_o = resp_prime_q;
    assign resp_err_o   = resp_err_q;
    assign gen_go_o     = gen_go_q;
    assign gen_rst_o    = gen_rst_q;

endmodule

// File: tb/tb_primogen_seq.sv
// Directed bench for primogen_seq against a small behavioural primogen stub
// (3-cycle step latency, 2-cycle restart latency, optional stall).
module tb_primogen_seq;

    localparam int WIDTH   = 16;
    localparam int IDX_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [IDX_W-1:0] req_idx;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_prime;
    logic             resp_err;
    logic             gen_rst;
    logic             gen_go;
    logic             gen_ready = 1'b0;
    logic             gen_error;
    logic [WIDTH-1:0] gen_res;

    always #5 clk = ~clk;

    primogen_seq #(.WIDTH(WIDTH), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_idx_i   (req_idx),
        .req_ready_o (req_ready),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_prime_o(resp_prime),
        .resp_err_o  (resp_err),
        .gen_rst_o   (gen_rst),
        .gen_go_o    (gen_go),
        .gen_ready_i (gen_ready),
        .gen_error_i (gen_error),
        .gen_res_i   (gen_res)
    );

    // primogen stub
    logic [WIDTH-1:0] primes [0:15];
    int  pos   = 0;
    int  cnt   = 0;
    logic stall = 1'b0;

    assign gen_res = primes[pos];

    always @(posedge clk) begin
        if (gen_rst) begin
            pos       <= 0;
            gen_ready <= 1'b0;
            cnt       <= 2;
        end else if (gen_go && gen_ready) begin
            pos       <= pos + 1;
            gen_ready <= 1'b0;
            cnt       <= 3;
        end else if (!gen_ready && !stall) begin
            if (cnt <= 1) gen_ready <= 1'b1;
            else          cnt <= cnt - 1;
        end
    end

    // pulse counters and gen_go protocol monitor
    int   go_total  = 0;
    int   rst_total = 0;
    int   go_bad    = 0;
    logic go_prev   = 1'b0;

    always @(posedge clk) begin
        if (gen_go) go_total <= go_total + 1;
        if (gen_rst) rst_total <= rst_total + 1;
        if (gen_go && (!gen_ready || go_prev)) go_bad <= go_bad + 1;
        go_prev <= gen_go;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic req_check(input string tag, input logic [IDX_W-1:0] idx,
                             input logic [WIDTH-1:0] exp_prime, input logic exp_err,
                             input int exp_go, input int exp_rst, input int hold,
                             output int lat);
        int go0;
        int rst0;
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_idx   = idx;
        go0       = go_total;
        rst0      = rst_total;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 600) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_prime"}, resp_prime, exp_prime);
        chk({tag, "_err"}, resp_err, exp_err);
        chk({tag, "_go_pulses"}, go_total - go0, exp_go);
        chk({tag, "_rst_pulses"}, rst_total - rst0, exp_rst);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, resp_valid, 1);
            chk({tag, "_hold_prime"}, resp_prime, exp_prime);
            chk({tag, "_hold_err"}, resp_err, exp_err);
            chk({tag, "_hold_req_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, resp_valid, 0);
        chk({tag, "_err_clear"}, resp_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int go0;
        primes[0]  = 16'd1;  primes[1]  = 16'd2;  primes[2]  = 16'd3;  primes[3]  = 16'd5;
        primes[4]  = 16'd7;  primes[5]  = 16'd11; primes[6]  = 16'd13; primes[7]  = 16'd17;
        primes[8]  = 16'd19; primes[9]  = 16'd23; primes[10] = 16'd29; primes[11] = 16'd31;
        primes[12] = 16'd37; primes[13] = 16'd41; primes[14] = 16'd43; primes[15] = 16'd47;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_idx    = '0;
        resp_ready = 1'b0;
        gen_error  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_prime", resp_prime, 0);
        chk("rst_gen_go", gen_go, 0);
        chk("rst_gen_rst", gen_rst, 1);

        rst_n = 1'b1;
        #1 chk("init_gen_rst_hi", gen_rst, 1);
        @(negedge clk);
        chk("init_gen_rst_lo", gen_rst, 0);

        req_check("idx0", 8'd0, 16'd1, 1'b0, 0, 0, 0, lat);
        req_check("idx5", 8'd5, 16'd11, 1'b0, 5, 0, 0, lat);
        req_check("idx12", 8'd12, 16'd37, 1'b0, 7, 0, 0, lat);
        req_check("idx3_back", 8'd3, 16'd5, 1'b0, 3, 1, 0, lat);
        req_check("idx3_hit", 8'd3, 16'd5, 1'b0, 0, 0, 0, lat);
        chk("idx3_hit_latency", lat, 1);
        req_check("idx4_hold", 8'd4, 16'd7, 1'b0, 1, 0, 10, lat);

        stall = 1'b1;
        req_check("idx6_timeout", 8'd6, 16'd0, 1'b1, 1, 0, 0, lat);
        chk("timeout_latency_bound", (lat <= TIMEOUT + 4), 1);
        stall = 1'b0;
        req_check("idx2_after_err", 8'd2, 16'd3, 1'b0, 2, 1, 0, lat);

        // reset while the third step of an idx-10 request is in WAIT_HI
        @(negedge clk);
        req_valid = 1'b1;
        req_idx   = 8'd10;
        go0       = go_total;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (go_total - go0 < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_go_pulses", go_total - go0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gen_go", gen_go, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_gen_rst", gen_rst, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_init_gen_rst_hi", gen_rst, 1);
        @(negedge clk);
        chk("mid_init_gen_rst_lo", gen_rst, 0);
        req_check("idx10", 8'd10, 16'd29, 1'b0, 10, 0, 0, lat);

        chk("gen_go_protocol", go_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
